// File: rtl/pwm_carrier_sched_pkg.sv
// Shared widths and update-mode encodings for the
// PWM carrier scheduler.
package pwm_carrier_sched_pkg;

  localparam int DW = 16;

  typedef enum logic [1:0] {
    UPD_VALLEY = 2'b00,
    UPD_PEAK   = 2'b01,
    UPD_BOTH   = 2'b10,
    UPD_IMM    = 2'b11
  } upd_mode_e;

endpackage

// File: rtl/pwm_tri_counter.sv
// Prescaled up/down triangle counter with peak/valley
// trigger pulses and a clamp when the maximum drops.
module pwm_tri_counter
  import pwm_carrier_sched_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [DW-1:0] divider,
  input  logic [DW-1:0] cmax,
  input  logic          ld,
  input  logic [DW-1:0] ld_max,
  output logic [DW-1:0] carrier,
  output logic          count_up,
  output logic          trig_peak,
  output logic          trig_valley
);

  logic [DW-1:0] presc;
  logic [DW-1:0] m;
  logic [DW-1:0] inc;
  logic [DW-1:0] dec;
  logic          tick;
  logic          go_up;

  // A load in this cycle already bounds the carrier.
  assign m     = ld ? ld_max : cmax;
  assign inc   = carrier + 1'b1;
  assign dec   = carrier - 1'b1;
  assign tick  = presc >= divider;
  assign go_up = (count_up && carrier < m) ||
                 (carrier == '0);

  // Prescaler, carrier, direction and trigger pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc       <= '0;
      carrier     <= '0;
      count_up    <= 1'b1;
      trig_peak   <= 1'b0;
      trig_valley <= 1'b0;
    end else begin
      trig_peak   <= 1'b0;
      trig_valley <= 1'b0;
      if (!enable) begin
        presc    <= '0;
        carrier  <= '0;
        count_up <= 1'b1;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (m == '0) begin
          carrier  <= '0;
          count_up <= 1'b1;
        end else if (carrier > m) begin
          carrier   <= m;
          count_up  <= 1'b0;
          trig_peak <= 1'b1;
        end else if (tick) begin
          if (go_up) begin
            carrier   <= inc;
            count_up  <= (inc != m);
            trig_peak <= (inc == m);
          end else begin
            carrier     <= dec;
            count_up    <= (dec == '0);
            trig_valley <= (dec == '0);
          end
        end
      end
    end
  end

endmodule

// File: rtl/pwm_carrier_sched.sv
// Double-buffered carrier_max/duty bank that loads
// at carrier valley/peak, plus the shared carrier.
module pwm_carrier_sched
  import pwm_carrier_sched_pkg::*;
#(
  parameter int N_LEGS = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [15:0]            divider,
  input  logic [1:0]             upd_mode,
  input  logic                   upd_req,
  input  logic [15:0]            carrier_max_in,
  input  logic [16*N_LEGS-1:0]   duty_in,
  output logic                   upd_ack,
  output logic                   pending,
  output logic [15:0]            carrier,
  output logic [15:0]            carrier_max,
  output logic [16*N_LEGS-1:0]   duty_out,
  output logic                   count_up,
  output logic                   trig_peak,
  output logic                   trig_valley
);

  localparam int BW = DW * N_LEGS;

  logic [DW-1:0] stg_max;
  logic [BW-1:0] stg_duty;
  logic          at_point;
  logic          load;
  upd_mode_e     mode;

  assign mode = upd_mode_e'(upd_mode);

  // Pick the load point for the selected mode.
  always_comb begin
    at_point = 1'b0;
    unique case (mode)
      UPD_VALLEY: at_point = trig_valley;
      UPD_PEAK:   at_point = trig_peak;
      UPD_BOTH:   at_point = trig_valley | trig_peak;
      UPD_IMM:    at_point = 1'b1;
    endcase
  end

  // A stopped carrier never reaches a load point,
  // so pending values go straight through.
  assign load = pending & (~enable | at_point);

  // Staging and active banks; a request racing a load
  // is kept for the next load point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_max     <= '0;
      stg_duty    <= '0;
      pending     <= 1'b0;
      carrier_max <= '0;
      duty_out    <= '0;
      upd_ack     <= 1'b0;
    end else begin
      upd_ack <= load;
      pending <= upd_req | (pending & ~load);
      if (load) begin
        carrier_max <= stg_max;
        duty_out    <= stg_duty;
      end
      if (upd_req) begin
        stg_max  <= carrier_max_in;
        stg_duty <= duty_in;
      end
    end
  end

  pwm_tri_counter u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .divider     (divider),
    .cmax        (carrier_max),
    .ld          (load),
    .ld_max      (stg_max),
    .carrier     (carrier),
    .count_up    (count_up),
    .trig_peak   (trig_peak),
    .trig_valley (trig_valley)
  );

endmodule
